// File: rtl/axis_addr_gen_2d.sv
// axis_addr_gen_2d: two-level (row/column) strided BRAM address generator with
// optional circular-region wrap, valid/ready output, last flags, abort and done.
module axis_addr_gen_2d #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_inner_len,
  input  logic [ADDR_W-1:0] cfg_inner_stride,
  input  logic [CNT_W-1:0]  cfg_outer_len,
  input  logic [ADDR_W-1:0] cfg_outer_stride,
  input  logic              cfg_wrap_en,
  input  logic [ADDR_W-1:0] cfg_wrap_top,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last_row,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_n;

  // Configuration captured at start so the run is immune to later cfg_* changes
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] inner_stride_q;
  logic [ADDR_W-1:0] outer_stride_q;
  logic [ADDR_W-1:0] wrap_top_q;
  logic [CNT_W-1:0]  inner_len_q;
  logic [CNT_W-1:0]  outer_len_q;
  logic              wrap_en_q;

  // Walk position
  logic [CNT_W-1:0]  inner_idx, inner_idx_n;
  logic [CNT_W-1:0]  outer_idx, outer_idx_n;
  logic [ADDR_W-1:0] row_start, row_start_n;

  // Next values of the registered outputs
  logic [ADDR_W-1:0] addr_n;
  logic              valid_n;
  logic              last_row_n;
  logic              last_n;
  logic              busy_n;
  logic              done_n;

  logic              cfg_load;
  logic [CNT_W-1:0]  len_inner;
  logic [CNT_W-1:0]  len_outer;
  logic [ADDR_W-1:0] inner_next;
  logic [ADDR_W-1:0] row_next;

  // Step an address; with wrap enabled the sum is folded back into [base, top]
  function automatic logic [ADDR_W-1:0] wrap_add(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] inc,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] top,
    input logic              wen
  );
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] span;
    sum  = {1'b0, a} + {1'b0, inc};
    span = {1'b0, top} - {1'b0, base} + SUM_W'(1);
    if (wen && (sum > {1'b0, top})) begin
      sum = sum - span;
    end
    return sum[ADDR_W-1:0];
  endfunction

  assign inner_next = wrap_add(addr, inner_stride_q, base_q, wrap_top_q, wrap_en_q);
  assign row_next   = wrap_add(row_start, outer_stride_q, base_q, wrap_top_q, wrap_en_q);

  // State, position, output and config registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      addr           <= '0;
      addr_valid     <= 1'b0;
      addr_last_row  <= 1'b0;
      addr_last      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      inner_idx      <= '0;
      outer_idx      <= '0;
      row_start      <= '0;
      base_q         <= '0;
      inner_stride_q <= '0;
      outer_stride_q <= '0;
      wrap_top_q     <= '0;
      inner_len_q    <= '0;
      outer_len_q    <= '0;
      wrap_en_q      <= 1'b0;
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      addr_valid    <= valid_n;
      addr_last_row <= last_row_n;
      addr_last     <= last_n;
      busy          <= busy_n;
      done          <= done_n;
      inner_idx     <= inner_idx_n;
      outer_idx     <= outer_idx_n;
      row_start     <= row_start_n;
      if (cfg_load) begin
        base_q         <= cfg_base;
        inner_stride_q <= cfg_inner_stride;
        outer_stride_q <= cfg_outer_stride;
        wrap_top_q     <= cfg_wrap_top;
        inner_len_q    <= cfg_inner_len;
        outer_len_q    <= cfg_outer_len;
        wrap_en_q      <= cfg_wrap_en;
      end
    end
  end

  // Next-state, next-address and flag computation
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    valid_n     = addr_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    row_start_n = row_start;
    inner_idx_n = inner_idx;
    outer_idx_n = outer_idx;
    cfg_load    = 1'b0;
    len_inner   = inner_len_q;
    len_outer   = outer_len_q;
    last_row_n  = 1'b0;
    last_n      = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          if ((cfg_inner_len != '0) && (cfg_outer_len != '0)) begin
            cfg_load    = 1'b1;
            state_n     = RUN;
            addr_n      = cfg_base;
            row_start_n = cfg_base;
            inner_idx_n = '0;
            outer_idx_n = '0;
            valid_n     = 1'b1;
            busy_n      = 1'b1;
            len_inner   = cfg_inner_len;
            len_outer   = cfg_outer_len;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_abort) begin
          state_n = IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end else if (addr_valid && addr_ready) begin
          if (addr_last) begin
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (addr_last_row) begin
            row_start_n = row_next;
            addr_n      = row_next;
            inner_idx_n = '0;
            outer_idx_n = outer_idx + CNT_W'(1);
          end else begin
            addr_n      = inner_next;
            inner_idx_n = inner_idx + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    if (valid_n) begin
      last_row_n = (inner_idx_n == (len_inner - CNT_W'(1)));
      last_n     = last_row_n && (outer_idx_n == (len_outer - CNT_W'(1)));
    end
  end

endmodule

// File: tb/tb_axis_addr_gen_2d.sv
// Bench for axis_addr_gen_2d: expected beats are queued at start, a negedge
// monitor pops and compares on every handshake and checks the done pulse.
module tb_axis_addr_gen_2d;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              cfg_start = 1'b0;
  logic              cfg_abort = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [CNT_W-1:0]  cfg_inner_len = '0;
  logic [ADDR_W-1:0] cfg_inner_stride = '0;
  logic [CNT_W-1:0]  cfg_outer_len = '0;
  logic [ADDR_W-1:0] cfg_outer_stride = '0;
  logic              cfg_wrap_en = 1'b0;
  logic [ADDR_W-1:0] cfg_wrap_top = '0;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready = 1'b0;
  logic              addr_last_row;
  logic              addr_last;
  logic              busy;
  logic              done;

  axis_addr_gen_2d #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_base         (cfg_base),
    .cfg_inner_len    (cfg_inner_len),
    .cfg_inner_stride (cfg_inner_stride),
    .cfg_outer_len    (cfg_outer_len),
    .cfg_outer_stride (cfg_outer_stride),
    .cfg_wrap_en      (cfg_wrap_en),
    .cfg_wrap_top     (cfg_wrap_top),
    .addr             (addr),
    .addr_valid       (addr_valid),
    .addr_ready       (addr_ready),
    .addr_last_row    (addr_last_row),
    .addr_last        (addr_last),
    .busy             (busy),
    .done             (done)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] a;
    logic        lr;
    logic        l;
  } beat_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] ilen;
    logic [15:0] istride;
    logic [15:0] olen;
    logic [15:0] ostride;
    bit          wen;
    logic [15:0] top;
  } cfg_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hs_count = 0;
  int    rdy_mode = 0;
  int    rdy_cnt = 0;
  bit    zs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: always, 1-0-0 pattern, or random
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: addr_ready = 1'b1;
      1: begin addr_ready = (rdy_cnt % 3 == 0); rdy_cnt++; end
      default: addr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops on handshake, checks stall stability and the done pulse
  bit          p_hs_last = 1'b0;
  bit          p_zs = 1'b0;
  bit          p_stall = 1'b0;
  logic [15:0] p_addr = '0;
  logic [1:0]  p_flags = '0;
  always @(negedge aclk) begin
    bit    exp_done;
    bit    hs;
    bit    popped_last;
    beat_t e;
    exp_done    = p_hs_last || p_zs;
    popped_last = 1'b0;
    if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
    if (p_stall && addr_valid) begin
      chk("stall_addr", 32'(addr), 32'(p_addr));
      chk("stall_flags", 32'({addr_last_row, addr_last}), 32'(p_flags));
    end
    hs = addr_valid && addr_ready;
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %0d expected no beat at %0t", addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("addr", 32'(addr), 32'(e.a));
        chk("last_row", 32'(addr_last_row), 32'(e.lr));
        chk("last", 32'(addr_last), 32'(e.l));
        popped_last = e.l;
      end
    end
    p_hs_last = hs && popped_last && !cfg_abort && !areset;
    p_zs      = zs && !cfg_abort && !areset;
    p_stall   = addr_valid && !addr_ready && !cfg_abort && !areset;
    p_addr    = addr;
    p_flags   = {addr_last_row, addr_last};
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference step: modular add, or fold back into the circular region
  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] inc,
                                        input cfg_t c);
    int s;
    s = int'(a) + int'(inc);
    if (c.wen && s > int'(c.top)) s = s - (int'(c.top) - int'(c.base) + 1);
    return 16'(s);
  endfunction

  // Reference run: rows of ilen addresses, olen rows
  task automatic model_push(input cfg_t c);
    logic [15:0] a;
    logic [15:0] row;
    a   = c.base;
    row = c.base;
    for (int o = 0; o < int'(c.olen); o++) begin
      for (int i = 0; i < int'(c.ilen); i++) begin
        exp_q.push_back({a, 1'(i == int'(c.ilen) - 1),
                         1'((i == int'(c.ilen) - 1) && (o == int'(c.olen) - 1))});
        if (i < int'(c.ilen) - 1) a = m_add(a, c.istride, c);
        else begin
          row = m_add(row, c.ostride, c);
          a   = row;
        end
      end
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_base         = c.base;
    cfg_inner_len    = c.ilen;
    cfg_inner_stride = c.istride;
    cfg_outer_len    = c.olen;
    cfg_outer_stride = c.ostride;
    cfg_wrap_en      = c.wen;
    cfg_wrap_top     = c.top;
  endtask

  task automatic start(input cfg_t c);
    drive_cfg(c);
    hs_count  = 0;
    cfg_start = 1'b1;
    zs        = (c.ilen == 0) || (c.olen == 0);
    tick();
    cfg_start = 1'b0;
    zs        = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_hs(input int target, input int limit);
    int n;
    n = 0;
    while (hs_count < target && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (hs_count < target) begin
      errors++;
      $display("FAIL hs_timeout: got %0d transfers expected %0d", hs_count, target);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_valid"}, 32'(addr_valid), 0);
    chk({tag, "_last_row"}, 32'(addr_last_row), 0);
    chk({tag, "_last"}, 32'(addr_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    int   size;
    c.ilen = 16'($urandom_range(1, 6));
    c.olen = 16'($urandom_range(1, 4));
    c.wen  = 1'($urandom_range(0, 1));
    if (c.wen) begin
      size      = int'($urandom_range(1, 64));
      c.base    = 16'($urandom_range(0, 65536 - size));
      c.top     = 16'(int'(c.base) + size - 1);
      c.istride = 16'($urandom_range(0, size));
      c.ostride = 16'($urandom_range(0, size));
    end else begin
      c.base    = 16'($urandom);
      c.top     = 16'($urandom);
      c.istride = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 8));
      c.ostride = 16'($urandom);
    end
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 1) c.ilen = '0;
      else c.olen = '0;
    end
    return c;
  endfunction

  cfg_t basic;
  cfg_t c;
  cfg_t other;
  logic [15:0] wrap_seq [6];

  initial begin
    basic = '{base: 16'd256, ilen: 16'd4, istride: 16'd1, olen: 16'd3,
              ostride: 16'd16, wen: 1'b0, top: 16'd0};
    other = '{base: 16'd999, ilen: 16'd7, istride: 16'd5, olen: 16'd2,
              ostride: 16'd100, wen: 1'b1, top: 16'd1200};

    // Reset state
    areset = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    areset = 1'b0;
    tick();

    // Basic 2D run, full throughput; expectations written out directly
    rdy_mode = 0;
    for (int o = 0; o < 3; o++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({16'(256 + 16 * o + i), 1'(i == 3), 1'(i == 3 && o == 2)});
    start(basic);
    wait_drain(100);
    tick();
    tick();

    // Backpressure with 1,0,0 ready; cfg_start mid-run must be ignored
    rdy_mode = 1;
    rdy_cnt  = 0;
    for (int o = 0; o < 3; o++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({16'(256 + 16 * o + i), 1'(i == 3), 1'(i == 3 && o == 2)});
    start(basic);
    tick();
    drive_cfg(other);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_drain(200);
    tick();
    tick();

    // Circular region wrap
    rdy_mode = 0;
    wrap_seq = '{16'd100, 16'd103, 16'd106, 16'd101, 16'd104, 16'd107};
    for (int i = 0; i < 6; i++) exp_q.push_back({wrap_seq[i], 1'(i == 5), 1'(i == 5)});
    c = '{base: 16'd100, ilen: 16'd6, istride: 16'd3, olen: 16'd1,
          ostride: 16'd0, wen: 1'b1, top: 16'd107};
    start(c);
    wait_drain(100);
    tick();
    tick();

    // Zero length: no beats, done next cycle only
    c = basic;
    c.ilen = '0;
    start(c);
    chk("zero_valid", 32'(addr_valid), 0);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_done", 32'(done), 1);
    tick();
    chk("zero_done_once", 32'(done), 0);
    chk("zero_valid2", 32'(addr_valid), 0);
    tick();

    // Abort after 5 transfers; the transfer in the abort cycle still counts
    model_push(basic);
    start(basic);
    wait_hs(5, 100);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_valid", 32'(addr_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_beats", 32'(hs_count), 6);
    exp_q.delete();
    tick();
    tick();

    // Restart after abort
    exp_q.push_back({16'd0, 1'b0, 1'b0});
    exp_q.push_back({16'd1, 1'b1, 1'b1});
    c = '{base: 16'd0, ilen: 16'd2, istride: 16'd1, olen: 16'd1,
          ostride: 16'd0, wen: 1'b0, top: 16'd0};
    start(c);
    wait_drain(50);
    tick();
    tick();

    // Reset mid-run
    model_push(basic);
    start(basic);
    tick();
    tick();
    areset = 1'b1;
    tick();
    check_outputs_zero("midreset");
    areset = 1'b0;
    exp_q.delete();
    tick();
    tick();

    // Randomized runs, back to back (next start lands in the done cycle)
    for (int r = 0; r < 60; r++) begin
      int total;
      rdy_mode = int'($urandom_range(0, 2));
      c = rand_cfg();
      total = int'(c.ilen) * int'(c.olen);
      model_push(c);
      start(c);
      if (total == 0) continue;
      if (total >= 3 && $urandom_range(0, 4) == 0) begin
        wait_hs(int'($urandom_range(1, total - 2)), 2000);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("rand_abort_valid", 32'(addr_valid), 0);
        exp_q.delete();
        tick();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          drive_cfg(rand_cfg());
          cfg_start = 1'b1;
          tick();
          cfg_start = 1'b0;
        end
        wait_drain(2000);
      end
    end

    tick();
    tick();
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
